// File: rtl/l2_pkg.sv
`default_nettype none
// ============================================================================
// Package     : l2_pkg
// Description : Shared types and constants for the two-core L2 responder:
//               owner FSM encoding, snoop tag/index field positions within a
//               word address, and bit offsets of the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
package l2_pkg;

    // Which core currently owns the backing store.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    // Word address layout: {tag[9:6], index[5:2], offset[1:0]}.
    localparam int TAG_MSB   = 9;
    localparam int TAG_LSB   = 6;
    localparam int INDEX_MSB = 5;
    localparam int INDEX_LSB = 2;

    // Statistics word layout: {c0_rd, c0_wr, c1_rd, c1_wr}, 8 bits each.
    localparam int STAT_W         = 8;
    localparam int STAT_C0_RD_LSB = 24;
    localparam int STAT_C0_WR_LSB = 16;
    localparam int STAT_C1_RD_LSB = 8;
    localparam int STAT_C1_WR_LSB = 0;

endpackage : l2_pkg
`default_nettype wire

// File: rtl/l2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_rr_arbiter
// Description : Two-way round-robin arbiter with ownership hold. A requester
//               is granted combinationally from IDLE and then keeps the grant
//               for as long as it holds its request. On a tie in IDLE the core
//               that was not served last wins.
// Ports       : clk, reset   - clock, asynchronous active-high reset
//               req[1:0]     - per-core request (read | write)
//               grant[1:0]   - per-core grant (one-hot or zero)
//               enter[1:0]   - pulse: core is granted from IDLE this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module l2_rr_arbiter
    import l2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic [1:0] enter
);

    owner_e r_owner;
    owner_e w_owner_next;
    logic   r_last_ptr;      // core served most recently
    logic   w_last_ptr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= IDLE;
            r_last_ptr <= 1'b1;  // core 0 wins the first tie
        end else begin
            r_owner    <= w_owner_next;
            r_last_ptr <= w_last_ptr_next;
        end
    end

    always_comb begin
        w_owner_next    = r_owner;
        w_last_ptr_next = r_last_ptr;
        grant           = 2'b00;
        enter           = 2'b00;
        case (r_owner)
            IDLE: begin
                if (req[0] && (!req[1] || r_last_ptr)) begin
                    grant[0]     = 1'b1;
                    enter[0]     = 1'b1;
                    w_owner_next = OWN0;
                end else if (req[1]) begin
                    grant[1]     = 1'b1;
                    enter[1]     = 1'b1;
                    w_owner_next = OWN1;
                end
            end
            // The owner keeps its grant through the cycle it drops the
            // request, so the other core can only win from IDLE next cycle.
            OWN0: begin
                grant[0] = 1'b1;
                if (!req[0]) begin
                    w_owner_next    = IDLE;
                    w_last_ptr_next = 1'b0;
                end
            end
            OWN1: begin
                grant[1] = 1'b1;
                if (!req[1]) begin
                    w_owner_next    = IDLE;
                    w_last_ptr_next = 1'b1;
                end
            end
            default: begin
                w_owner_next = IDLE;
            end
        endcase
        // No grant may leak out while reset is held (it would write memory).
        if (reset) begin
            grant = 2'b00;
            enter = 2'b00;
        end
    end

endmodule : l2_rr_arbiter
`default_nettype wire

// File: rtl/l2_coherent_responder.sv
`default_nettype none
// ============================================================================
// Module      : l2_coherent_responder
// Description : Shared L2 responder for two L1 caches. Arbitrates requests,
//               serves them from a word-addressed backing store, stalls the
//               losing core via its busy clock-enable and broadcasts the
//               granted transaction to the other core as a snoop.
// Ports       : clk, reset                - clock, async active-high reset
//               cK_word_address/write_word - core K request address / data
//               cK_read/write_request      - core K request levels
//               cK_read_word               - registered read data to core K
//               cK_busy                    - stall to core K (high = freeze)
//               cK_others_*                - snoop of the other core's access
//               l2_statistics              - {c0_rd,c0_wr,c1_rd,c1_wr} counts
// Revision    : 1.0 - initial release
// ============================================================================
module l2_coherent_responder
    import l2_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] c0_word_address,
    input  logic [N-1:0]      c0_write_word,
    input  logic              c0_read_request,
    input  logic              c0_write_request,
    output logic [N-1:0]      c0_read_word,
    output logic              c0_busy,
    output logic              c0_others_read_request,
    output logic              c0_others_write_request,
    output logic [3:0]        c0_others_block_tag,
    output logic [3:0]        c0_others_block_index,
    input  logic [ADDR_W-1:0] c1_word_address,
    input  logic [N-1:0]      c1_write_word,
    input  logic              c1_read_request,
    input  logic              c1_write_request,
    output logic [N-1:0]      c1_read_word,
    output logic              c1_busy,
    output logic              c1_others_read_request,
    output logic              c1_others_write_request,
    output logic [3:0]        c1_others_block_tag,
    output logic [3:0]        c1_others_block_index,
    output logic [31:0]       l2_statistics
);

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic [1:0]        w_enter;
    logic              w_rd_en0;
    logic              w_rd_en1;
    logic              w_wr_en0;
    logic              w_wr_en1;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [N-1:0]      w_mem_wdata;

    logic [N-1:0]      r_mem [DEPTH];
    logic [N-1:0]      r_read_word0;
    logic [N-1:0]      r_read_word1;
    logic [STAT_W-1:0] r_c0_rd;
    logic [STAT_W-1:0] r_c0_wr;
    logic [STAT_W-1:0] r_c1_rd;
    logic [STAT_W-1:0] r_c1_wr;

    assign w_req = {c1_read_request | c1_write_request,
                    c0_read_request | c0_write_request};

    l2_rr_arbiter u_arbiter (
        .clk   (clk),
        .reset (reset),
        .req   (w_req),
        .grant (w_grant),
        .enter (w_enter)
    );

    // A simultaneous read+write is treated as a write; the read is dropped.
    assign w_wr_en0 = w_grant[0] & c0_write_request;
    assign w_wr_en1 = w_grant[1] & c1_write_request;
    assign w_rd_en0 = w_grant[0] & c0_read_request & ~c0_write_request;
    assign w_rd_en1 = w_grant[1] & c1_read_request & ~c1_write_request;

    // Grants are exclusive, so a single write port suffices.
    assign w_mem_we    = w_wr_en0 | w_wr_en1;
    assign w_mem_addr  = w_grant[1] ? c1_word_address : c0_word_address;
    assign w_mem_wdata = w_grant[1] ? c1_write_word   : c0_write_word;

    // Backing store has no reset: contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered reads: a read the cycle after a write to the same word
    // naturally sees the new data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_word0 <= '0;
            r_read_word1 <= '0;
        end else begin
            if (w_rd_en0) begin
                r_read_word0 <= r_mem[c0_word_address];
            end
            if (w_rd_en1) begin
                r_read_word1 <= r_mem[c1_word_address];
            end
        end
    end

    assign c0_read_word = r_read_word0;
    assign c1_read_word = r_read_word1;

    // Only a requesting core is ever stalled; grants are already forced low
    // during reset, the explicit gate keeps busy low even for stray requests.
    assign c0_busy = ~reset & w_req[0] & ~w_grant[0];
    assign c1_busy = ~reset & w_req[1] & ~w_grant[1];

    // Snoop of core 0's transaction, seen by core 1.
    assign c1_others_read_request  = w_grant[0] & c0_read_request & ~c0_write_request;
    assign c1_others_write_request = w_grant[0] & c0_write_request;
    assign c1_others_block_tag     = w_grant[0] ? c0_word_address[TAG_MSB:TAG_LSB]     : 4'h0;
    assign c1_others_block_index   = w_grant[0] ? c0_word_address[INDEX_MSB:INDEX_LSB] : 4'h0;

    // Snoop of core 1's transaction, seen by core 0.
    assign c0_others_read_request  = w_grant[1] & c1_read_request & ~c1_write_request;
    assign c0_others_write_request = w_grant[1] & c1_write_request;
    assign c0_others_block_tag     = w_grant[1] ? c1_word_address[TAG_MSB:TAG_LSB]     : 4'h0;
    assign c0_others_block_index   = w_grant[1] ? c1_word_address[INDEX_MSB:INDEX_LSB] : 4'h0;

    // One count per ownership, classified by the request type at entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c0_rd <= '0;
            r_c0_wr <= '0;
            r_c1_rd <= '0;
            r_c1_wr <= '0;
        end else begin
            if (w_enter[0]) begin
                if (c0_write_request) begin
                    r_c0_wr <= r_c0_wr + 8'd1;
                end else begin
                    r_c0_rd <= r_c0_rd + 8'd1;
                end
            end
            if (w_enter[1]) begin
                if (c1_write_request) begin
                    r_c1_wr <= r_c1_wr + 8'd1;
                end else begin
                    r_c1_rd <= r_c1_rd + 8'd1;
                end
            end
        end
    end

    always_comb begin
        l2_statistics = 32'h0;
        l2_statistics[STAT_C0_RD_LSB +: STAT_W] = r_c0_rd;
        l2_statistics[STAT_C0_WR_LSB +: STAT_W] = r_c0_wr;
        l2_statistics[STAT_C1_RD_LSB +: STAT_W] = r_c1_rd;
        l2_statistics[STAT_C1_WR_LSB +: STAT_W] = r_c1_wr;
    end

endmodule : l2_coherent_responder
`default_nettype wire

// File: tb/tb_l2_coherent_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_coherent_responder
// Description : Self-checking bench for l2_coherent_responder. Each stimulus
//               cycle carries the expected grants; read data expected from a
//               memory model is queued when a read is issued and compared
//               when the registered data appears one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_coherent_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  c0_word_address, c1_word_address;
    logic [31:0] c0_write_word, c1_write_word;
    logic        c0_read_request, c0_write_request;
    logic        c1_read_request, c1_write_request;
    logic [31:0] c0_read_word, c1_read_word;
    logic        c0_busy, c1_busy;
    logic        c0_others_read_request, c0_others_write_request;
    logic        c1_others_read_request, c1_others_write_request;
    logic [3:0]  c0_others_block_tag, c0_others_block_index;
    logic [3:0]  c1_others_block_tag, c1_others_block_index;
    logic [31:0] l2_statistics;

    always #5 clk = ~clk;

    l2_coherent_responder dut (
        .clk                     (clk),
        .reset                   (reset),
        .c0_word_address         (c0_word_address),
        .c0_write_word           (c0_write_word),
        .c0_read_request         (c0_read_request),
        .c0_write_request        (c0_write_request),
        .c0_read_word            (c0_read_word),
        .c0_busy                 (c0_busy),
        .c0_others_read_request  (c0_others_read_request),
        .c0_others_write_request (c0_others_write_request),
        .c0_others_block_tag     (c0_others_block_tag),
        .c0_others_block_index   (c0_others_block_index),
        .c1_word_address         (c1_word_address),
        .c1_write_word           (c1_write_word),
        .c1_read_request         (c1_read_request),
        .c1_write_request        (c1_write_request),
        .c1_read_word            (c1_read_word),
        .c1_busy                 (c1_busy),
        .c1_others_read_request  (c1_others_read_request),
        .c1_others_write_request (c1_others_write_request),
        .c1_others_block_tag     (c1_others_block_tag),
        .c1_others_block_index   (c1_others_block_index),
        .l2_statistics           (l2_statistics)
    );

    int          n_total = 0;
    int          n_bad   = 0;

    // Reference state
    logic [31:0] m_mem [1024];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] exp_rd0, exp_rd1;
    logic [7:0]  s_c0_rd, s_c0_wr, s_c1_rd, s_c1_wr;
    logic        own0, own1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        own0 = 1'b0; own1 = 1'b0;
        s_c0_rd = 8'd0; s_c0_wr = 8'd0; s_c1_rd = 8'd0; s_c1_wr = 8'd0;
        exp_rd0 = 32'h0; exp_rd1 = 32'h0;
        q0.delete(); q1.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd0"},    c0_read_word, 32'h0);
        chk({tag, "_rd1"},    c1_read_word, 32'h0);
        chk({tag, "_busy0"},  32'(c0_busy), 32'h0);
        chk({tag, "_busy1"},  32'(c1_busy), 32'h0);
        chk({tag, "_snoop0"}, 32'({c0_others_read_request, c0_others_write_request,
                                    c0_others_block_tag, c0_others_block_index}), 32'h0);
        chk({tag, "_snoop1"}, 32'({c1_others_read_request, c1_others_write_request,
                                    c1_others_block_tag, c1_others_block_index}), 32'h0);
        chk({tag, "_stats"},  l2_statistics, 32'h0);
    endtask

    // Called just after a rising edge. Requests are left driven during reset
    // to prove that nothing is granted or written while it is held.
    task automatic pulse_reset(input logic r0, input logic w1);
        c0_read_request  = r0;   c0_write_request = 1'b0; c0_word_address = 10'h1C2;
        c1_read_request  = 1'b0; c1_write_request = w1;   c1_word_address = 10'h3FF;
        c1_write_word    = 32'h0;
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_now");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset_held");
        c0_read_request = 1'b0; c1_write_request = 1'b0;
        reset = 1'b0;
    endtask

    // One request cycle with the expected grants g0/g1. Called just after a
    // rising edge; returns just after the next rising edge.
    task automatic cyc(input logic r0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                       input logic g0, input logic g1);
        c0_read_request = r0; c0_write_request = w0; c0_word_address = a0; c0_write_word = d0;
        c1_read_request = r1; c1_write_request = w1; c1_word_address = a1; c1_write_word = d1;
        #4;
        chk("c0_busy",   32'(c0_busy), 32'((r0 | w0) & ~g0));
        chk("c1_busy",   32'(c1_busy), 32'((r1 | w1) & ~g1));
        chk("c1_oth_rd", 32'(c1_others_read_request),  32'(g0 & r0 & ~w0));
        chk("c1_oth_wr", 32'(c1_others_write_request), 32'(g0 & w0));
        chk("c1_oth_tag", 32'(c1_others_block_tag),   g0 ? 32'(a0[9:6]) : 32'h0);
        chk("c1_oth_idx", 32'(c1_others_block_index), g0 ? 32'(a0[5:2]) : 32'h0);
        chk("c0_oth_rd", 32'(c0_others_read_request),  32'(g1 & r1 & ~w1));
        chk("c0_oth_wr", 32'(c0_others_write_request), 32'(g1 & w1));
        chk("c0_oth_tag", 32'(c0_others_block_tag),   g1 ? 32'(a1[9:6]) : 32'h0);
        chk("c0_oth_idx", 32'(c0_others_block_index), g1 ? 32'(a1[5:2]) : 32'h0);
        if (g0 && r0 && !w0) q0.push_back(m_mem[a0]);
        if (g1 && r1 && !w1) q1.push_back(m_mem[a1]);
        if (g0 && w0) m_mem[a0] = d0;
        if (g1 && w1) m_mem[a1] = d1;
        if (g0 && !own0) begin
            if (w0) s_c0_wr++; else s_c0_rd++;
        end
        if (g1 && !own1) begin
            if (w1) s_c1_wr++; else s_c1_rd++;
        end
        own0 = g0 & (r0 | w0);
        own1 = g1 & (r1 | w1);
        @(posedge clk);
        #1;
        if (q0.size() > 0) exp_rd0 = q0.pop_front();
        if (q1.size() > 0) exp_rd1 = q1.pop_front();
        chk("c0_read_word",  c0_read_word,  exp_rd0);
        chk("c1_read_word",  c1_read_word,  exp_rd1);
        chk("l2_statistics", l2_statistics, {s_c0_rd, s_c0_wr, s_c1_rd, s_c1_wr});
    endtask

    task automatic idle();
        cyc(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        c0_read_request = 1'b0; c0_write_request = 1'b0; c0_word_address = '0; c0_write_word = '0;
        c1_read_request = 1'b0; c1_write_request = 1'b0; c1_word_address = '0; c1_write_word = '0;
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset(1'b1, 1'b1);
        idle();

        // Preload via one core-1 write ownership: mem[i] = i*3 at 0x1C0..0x1C3
        cyc(0, 0, 10'h0, 32'h0, 0, 1, 10'h1C0, 32'h540, 0, 1);
        cyc(0, 0, 10'h0, 32'h0, 0, 1, 10'h1C1, 32'h543, 0, 1);
        cyc(0, 0, 10'h0, 32'h0, 0, 1, 10'h1C2, 32'h546, 0, 1);
        cyc(0, 0, 10'h0, 32'h0, 0, 1, 10'h1C3, 32'h549, 0, 1);
        cyc(0, 0, 10'h0, 32'h0, 0, 1, 10'h025, 32'h0BADF00D, 0, 1);
        cyc(0, 0, 10'h0, 32'h0, 0, 0, 10'h0, 32'h0, 0, 1);
        idle();
        @(posedge clk);
        #1;
        pulse_reset(1'b0, 1'b0);

        // Single refill burst from core 0 (last address repeated)
        cyc(1, 0, 10'h1C0, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(1, 0, 10'h1C1, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(1, 0, 10'h1C2, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(1, 0, 10'h1C3, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(1, 0, 10'h1C3, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        idle();
        @(posedge clk);
        #1;
        pulse_reset(1'b0, 1'b0);

        // Simultaneous requests after reset: core 0 wins, core 1 stalls
        cyc(1, 0, 10'h025, 32'h0, 0, 1, 10'h025, 32'h12345678, 1, 0);
        cyc(1, 0, 10'h025, 32'h0, 0, 1, 10'h025, 32'h12345678, 1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 1, 10'h025, 32'h12345678, 1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 1, 10'h025, 32'h12345678, 0, 1);
        cyc(0, 0, 10'h0,   32'h0, 0, 1, 10'h025, 32'h12345678, 0, 1);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0,   32'h0,        0, 1);
        // Round-robin ties: core 1 served last -> core 0, then core 1
        cyc(1, 0, 10'h025, 32'h0, 1, 0, 10'h1C1, 32'h0, 1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0,   32'h0, 1, 0);
        cyc(1, 0, 10'h1C0, 32'h0, 1, 0, 10'h1C1, 32'h0, 0, 1);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0,   32'h0, 0, 1);
        // Owner drops while the other raises: hand-off one cycle later
        cyc(1, 0, 10'h1C2, 32'h0, 0, 0, 10'h0,   32'h0,        1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 1, 10'h100, 32'hA5A5A5A5, 1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 1, 10'h100, 32'hA5A5A5A5, 0, 1);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0,   32'h0,        0, 1);
        cyc(1, 0, 10'h100, 32'h0, 0, 0, 10'h0,   32'h0,        1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0,   32'h0,        1, 0);
        idle();
        @(posedge clk);
        #1;
        pulse_reset(1'b0, 1'b0);

        // Write-then-read through the shared store
        cyc(0, 0, 10'h0,   32'h0, 0, 1, 10'h3FF, 32'hDEADBEEF, 0, 1);
        cyc(0, 0, 10'h0,   32'h0, 0, 1, 10'h3FF, 32'hDEADBEEF, 0, 1);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0,   32'h0,        0, 1);
        cyc(1, 0, 10'h3FF, 32'h0, 0, 0, 10'h0,   32'h0,        1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0,   32'h0,        1, 0);
        idle();

        // Reset asserted on the third refill cycle of core 0
        cyc(1, 0, 10'h1C0, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(1, 0, 10'h1C1, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        pulse_reset(1'b1, 1'b1);
        // Memory retained, counters restarted, FSM back in IDLE
        cyc(1, 0, 10'h3FF, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(1, 0, 10'h1C0, 32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        cyc(0, 0, 10'h0,   32'h0, 0, 0, 10'h0, 32'h0, 1, 0);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_l2_coherent_responder
`default_nettype wire
